// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsm_pkg
// Description : Shared types and constants for the delta-sigma DAC.
//               - dsm_state_t : IDLE / RUN controller states
//               - c_ORDER_MIN / c_ORDER_MAX : legal modulator orders
//               - cnt_width() : counter width for a 0..n-1 count (min 1 bit)
// Revision    : 1.0 - initial release
// ============================================================================
package dsm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dsm_state_t;

    localparam int c_ORDER_MIN = 1;
    localparam int c_ORDER_MAX = 2;

    // A counter for 0..n-1 still needs one bit when n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsm_integrator.sv
`default_nettype none
// ============================================================================
// Module      : dsm_integrator
// Description : One saturating accumulator stage of the modulator loop.
//               acc_nxt = sat(acc + add_in - fb), registered when en=1.
// Ports       : clk     - clock
//               rst     - asynchronous active-low reset
//               clr     - synchronous clear of the accumulator
//               en      - load acc_nxt into the accumulator
//               add_in  - signed input term (AW bits)
//               fb      - signed feedback term (AW bits)
//               acc_nxt - signed saturated next value (combinational)
//               clip    - acc_nxt was clamped (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module dsm_integrator #(
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [AW-1:0] add_in,
    input  logic [AW-1:0] fb,
    output logic [AW-1:0] acc_nxt,
    output logic          clip
);

    // Two guard bits hold the raw three-term sum without wrapping.
    localparam int c_SW = AW + 2;
    localparam logic signed [c_SW-1:0] c_MAX = {3'b000, {(AW-1){1'b1}}};
    localparam logic signed [c_SW-1:0] c_MIN = {3'b111, {(AW-1){1'b0}}};

    logic [AW-1:0]          r_acc;
    logic signed [c_SW-1:0] w_sum;

    always_comb begin
        w_sum = $signed({{2{r_acc[AW-1]}}, r_acc})
              + $signed({{2{add_in[AW-1]}}, add_in})
              - $signed({{2{fb[AW-1]}}, fb});
        clip    = 1'b0;
        acc_nxt = w_sum[AW-1:0];
        if (w_sum > c_MAX) begin
            acc_nxt = c_MAX[AW-1:0];
            clip    = 1'b1;
        end else if (w_sum < c_MIN) begin
            acc_nxt = c_MIN[AW-1:0];
            clip    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= acc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsm_dac_v2.sv
`default_nettype none
// ============================================================================
// Module      : dsm_dac_v2
// Description : 1st/2nd-order delta-sigma DAC with a one-entry sample buffer.
//               A tick occurs every DIV clocks while running; every OSR ticks
//               the buffered sample becomes the active sample.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset
//               enable   - run request (level)
//               s_data   - signed input sample, WIDTH bits
//               s_valid  - s_data valid
//               s_ready  - holding buffer empty, sample can be accepted
//               dsm_out  - registered 1-bit modulator output
//               underrun - sticky: a load tick found the buffer empty
//               sat_flag - sticky: an accumulator clipped
// Revision    : 1.0 - initial release
// ============================================================================
module dsm_dac_v2 import dsm_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int EXT   = 4,
    parameter int ORDER = 2,
    parameter int DIV   = 4,
    parameter int OSR   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dsm_out,
    output logic             underrun,
    output logic             sat_flag
);

    localparam int c_AW     = WIDTH + EXT;
    localparam int c_STAGES = (ORDER >= c_ORDER_MAX) ? c_ORDER_MAX : c_ORDER_MIN;
    localparam int c_DW     = cnt_width(DIV);
    localparam int c_OW     = cnt_width(OSR);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(DIV - 1);
    localparam logic [c_OW-1:0] c_OSR_LAST = c_OW'(OSR - 1);
    localparam logic [c_AW-1:0] c_FB_POS   = c_AW'(1) << (WIDTH - 1);
    localparam logic [c_AW-1:0] c_FB_NEG   = ~c_FB_POS + c_AW'(1);

    dsm_state_t        r_state;
    dsm_state_t        w_state_nxt;
    logic              w_run;
    logic              w_start;
    logic              w_tick;
    logic              w_step;
    logic              w_stop;
    logic              w_clr;
    logic              w_load;
    logic              w_take;
    logic              w_xfer;
    logic [c_DW-1:0]   r_div;
    logic [c_OW-1:0]   r_osr;
    logic [WIDTH-1:0]  r_buf;
    logic              r_buf_full;
    logic [WIDTH-1:0]  r_active;
    logic [WIDTH-1:0]  w_x;
    logic [c_AW-1:0]   w_x_ext;
    logic [c_AW-1:0]   w_fb;
    logic [c_AW-1:0]   w_acc_nxt [c_STAGES];
    logic [c_STAGES-1:0] w_clip;
    logic              r_dsm;
    logic              r_under;
    logic              r_sat;

    // ---------------- controller: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- controller: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = RUN;
            RUN:     if (w_tick && !enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- controller: outputs ----------------
    // The tick that notices enable=0 only shuts down; it does no load or
    // integration, so the buffered sample survives for the next run.
    always_comb begin
        w_run   = (r_state == RUN);
        w_start = (r_state == IDLE) && enable;
        w_tick  = w_run && (r_div == c_DIV_LAST);
        w_step  = w_tick && enable;
        w_stop  = w_tick && !enable;
        w_clr   = !w_run || w_stop;
        w_load  = w_step && (r_osr == '0);
    end

    // ---------------- tick / load counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_osr <= '0;
        end else begin
            if (w_clr || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + c_DW'(1);
            end
            if (w_clr) begin
                r_osr <= '0;
            end else if (w_step) begin
                r_osr <= (r_osr == c_OSR_LAST) ? '0 : r_osr + c_OW'(1);
            end
        end
    end

    // ---------------- holding buffer and active sample ----------------
    // A transfer needs an empty buffer and a load consumes only a full one,
    // so the two never act on the buffer in the same cycle.
    assign w_xfer  = s_valid && !r_buf_full;
    assign w_take  = w_load && r_buf_full;
    assign s_ready = !r_buf_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_active   <= '0;
        end else begin
            if (w_xfer) begin
                r_buf      <= s_data;
                r_buf_full <= 1'b1;
            end else if (w_take) begin
                r_buf_full <= 1'b0;
            end
            if (w_take) begin
                r_active <= r_buf;
            end
        end
    end

    // The load tick already integrates the newly loaded sample.
    assign w_x     = w_take ? r_buf : r_active;
    assign w_x_ext = {{EXT{w_x[WIDTH-1]}}, w_x};
    assign w_fb    = r_dsm ? c_FB_POS : c_FB_NEG;

    // ---------------- integrator chain ----------------
    for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
        logic [c_AW-1:0] w_add;
        if (k == 0) begin : g_first
            assign w_add = w_x_ext;
        end else begin : g_chain
            assign w_add = w_acc_nxt[k-1];
        end
        dsm_integrator #(
            .AW (c_AW)
        ) u_integrator (
            .clk     (clk),
            .rst     (rst),
            .clr     (w_clr),
            .en      (w_step),
            .add_in  (w_add),
            .fb      (w_fb),
            .acc_nxt (w_acc_nxt[k]),
            .clip    (w_clip[k])
        );
    end

    // ---------------- output bit and sticky flags ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dsm   <= 1'b0;
            r_under <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            if (w_clr) begin
                r_dsm <= 1'b0;
            end else if (w_step) begin
                r_dsm <= ~w_acc_nxt[c_STAGES-1][c_AW-1];
            end
            if (w_start) begin
                r_under <= 1'b0;
            end else if (w_load && !r_buf_full) begin
                r_under <= 1'b1;
            end
            if (w_start) begin
                r_sat <= 1'b0;
            end else if (w_step && (|w_clip)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign dsm_out  = r_dsm;
    assign underrun = r_under;
    assign sat_flag = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_dsm_dac_v2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dsm_dac_v2
// Description : Self-checking bench for dsm_dac_v2 (WIDTH=16, EXT=4, ORDER=2,
//               DIV=4, OSR=8). A tick-level behavioural model tracks the
//               expected outputs every cycle; directed steps add density,
//               latency, throughput, reset and disable checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsm_dac_v2;

    localparam int c_WIDTH = 16;
    localparam int c_EXT   = 4;
    localparam int c_ORDER = 2;
    localparam int c_DIV   = 4;
    localparam int c_OSR   = 8;
    localparam int c_FS    = 2 ** (c_WIDTH - 1);
    localparam int c_AMAX  = 2 ** (c_WIDTH + c_EXT - 1) - 1;
    localparam int c_AMIN  = -(2 ** (c_WIDTH + c_EXT - 1));
    localparam int c_NTICK = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        dsm_out;
    logic        underrun;
    logic        sat_flag;

    int checks  = 0;
    int errors  = 0;
    int accepts = 0;

    // behavioural model state
    bit m_run, m_out, m_full, m_under, m_sat;
    int m_cyc, m_ticks, m_a1, m_a2, m_x, m_buf;

    dsm_dac_v2 #(
        .WIDTH (c_WIDTH),
        .EXT   (c_EXT),
        .ORDER (c_ORDER),
        .DIV   (c_DIV),
        .OSR   (c_OSR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .dsm_out  (dsm_out),
        .underrun (underrun),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_out = 0; m_full = 0; m_under = 0; m_sat = 0;
        m_cyc = 0; m_ticks = 0; m_a1 = 0; m_a2 = 0; m_x = 0; m_buf = 0;
    endtask

    function automatic int clampm(input int v);
        if (v > c_AMAX) return c_AMAX;
        if (v < c_AMIN) return c_AMIN;
        return v;
    endfunction

    // One rising edge of the reference: tick every DIV run cycles, sample
    // load every OSR ticks, then the two-integrator loop in plain integers.
    task automatic model_edge();
        bit xfer;
        bit tick;
        int f;
        int raw;
        if (!rst) begin
            model_reset();
            return;
        end
        xfer = s_valid && !m_full;
        tick = m_run && ((m_cyc % c_DIV) == c_DIV - 1);
        if (!m_run) begin
            if (enable) begin
                m_run = 1; m_cyc = 0; m_ticks = 0; m_under = 0; m_sat = 0;
            end
        end else if (tick && !enable) begin
            m_run = 0; m_a1 = 0; m_a2 = 0; m_out = 0;
        end else begin
            if (tick) begin
                if ((m_ticks % c_OSR) == 0) begin
                    if (m_full) begin
                        m_x = m_buf; m_full = 0;
                    end else begin
                        m_under = 1;
                    end
                end
                f   = m_out ? c_FS : -c_FS;
                raw = m_a1 + m_x - f;
                m_a1 = clampm(raw);
                if (raw != m_a1) m_sat = 1;
                raw = m_a2 + m_a1 - f;
                m_a2 = clampm(raw);
                if (raw != m_a2) m_sat = 1;
                m_out = (m_a2 >= 0);
                m_ticks++;
            end
            m_cyc++;
        end
        if (xfer) begin
            m_buf  = int'($signed(s_data));
            m_full = 1;
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic cyc();
        if (s_valid && s_ready) accepts++;
        @(posedge clk);
        model_edge();
        #1;
        chk("dsm_out",  32'(dsm_out),  32'(m_out));
        chk("s_ready",  32'(s_ready),  32'(!m_full));
        chk("underrun", 32'(underrun), 32'(m_under));
        chk("sat_flag", 32'(sat_flag), 32'(m_sat));
    endtask

    // Pulse rst low between edges; outputs must react without a clock.
    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        chk("rst_dsm_out",  32'(dsm_out),  32'd0);
        chk("rst_s_ready",  32'(s_ready),  32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);
        model_reset();
        enable  = 1'b0;
        s_valid = 1'b0;
        cyc();
        cyc();
        #3;
        rst = 1'b1;
        cyc();
    endtask

    task automatic density(input logic [15:0] d, input string tag);
        int ones;
        int expc;
        do_reset();
        s_data  = d;
        s_valid = 1'b1;
        enable  = 1'b1;
        cyc();
        ones = 0;
        for (int i = 0; i < c_NTICK; i++) begin
            repeat (c_DIV) cyc();
            ones += int'(dsm_out);
        end
        expc = (c_NTICK * (c_FS + int'($signed(d)))) / (2 * c_FS);
        checks++;
        assert ((ones >= expc - 1) && (ones <= expc + 1)) else begin
            errors++;
            $error("FAIL %s ones=%0d required=%0d+/-1", tag, ones, expc);
        end
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_sat_flag"}, 32'(sat_flag), 32'd0);
    endtask

    initial begin
        int n;
        rst     = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        model_reset();

        // reset state
        #1;
        chk("init_dsm_out",  32'(dsm_out),  32'd0);
        chk("init_s_ready",  32'(s_ready),  32'd1);
        chk("init_underrun", 32'(underrun), 32'd0);
        chk("init_sat_flag", 32'(sat_flag), 32'd0);
        cyc();
        cyc();
        #3;
        rst = 1'b1;
        cyc();

        // ones density for mid-scale, +half and -half inputs
        density(16'h0000, "dens_zero");
        density(16'h4000, "dens_pos_half");
        density(16'hC000, "dens_neg_half");

        // underrun: one sample, then starve; flag rises one load period later
        do_reset();
        s_data  = 16'h1234;
        s_valid = 1'b1;
        cyc();
        s_valid = 1'b0;
        enable  = 1'b1;
        cyc();
        n = 0;
        while (!underrun && n < 100) begin
            cyc();
            n++;
        end
        chk("underrun_latency", 32'(n), 32'(c_DIV + c_DIV * c_OSR));

        // backpressure: s_valid held high, one accept per load period
        do_reset();
        s_valid = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data = 16'($urandom_range(0, 32767)) - 16'd16384;
            cyc();
        end
        accepts = 0;
        for (int i = 0; i < 10 * c_DIV * c_OSR; i++) begin
            s_data = 16'($urandom_range(0, 32767)) - 16'd16384;
            cyc();
        end
        chk("bp_accepts", 32'(accepts), 32'd10);

        // mid-run reset, then idle until enable is seen high
        do_reset();
        repeat (10) cyc();
        chk("post_rst_idle_out", 32'(dsm_out), 32'd0);
        s_data  = 16'h2000;
        s_valid = 1'b1;
        enable  = 1'b1;
        repeat (20) cyc();

        // disable mid-sample, then re-enable clears the flags
        do_reset();
        s_data  = 16'h0000;
        s_valid = 1'b1;
        enable  = 1'b1;
        repeat (40) cyc();
        s_valid = 1'b0;
        repeat (80) cyc();
        chk("dis_underrun_set", 32'(underrun), 32'd1);
        repeat ($urandom_range(1, 3)) cyc();
        enable = 1'b0;
        repeat (12) cyc();
        chk("dis_idle_out",        32'(dsm_out),  32'd0);
        chk("dis_underrun_sticky", 32'(underrun), 32'd1);
        enable = 1'b1;
        cyc();
        chk("reen_underrun_clr", 32'(underrun), 32'd0);
        chk("reen_sat_clr",      32'(sat_flag), 32'd0);

        // full-scale negative input drives the second integrator into the rail
        do_reset();
        s_data  = 16'h8000;
        s_valid = 1'b1;
        enable  = 1'b1;
        repeat (200) cyc();
        chk("fullscale_sat_set", 32'(sat_flag), 32'd1);
        chk("fullscale_out_low", 32'(dsm_out),  32'd0);

        // randomized traffic with occasional enable toggles
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) enable = !enable;
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom_range(0, 32767)) - 16'd16384;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsm_dac_v2.md
DSM_DAC_V2 -- requirements
Module: dsm_dac_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the signed two's-complement input sample.
REQ-002 SHALL have parameter EXT, default 4: accumulator headroom bits, so each accumulator is WIDTH+EXT bits.
REQ-003 SHALL have parameter ORDER, default 2: modulator order; legal values are 1 and 2.
REQ-004 SHALL have parameter DIV, default 4: clk cycles per modulator tick (DIV >= 1).
REQ-005 SHALL have parameter OSR, default 8: modulator ticks per input sample (OSR >= 1).
REQ-006 SHALL have clk  input  1  the single clock; all flops sample on its rising edge.
REQ-007 SHALL have rst  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have enable  input  1  level-sensitive run request.
REQ-009 SHALL have s_data  input  WIDTH  signed input sample.
REQ-010 SHALL have s_valid  input  1  s_data is valid.
REQ-011 SHALL have s_ready  output  1  the holding buffer can accept a sample.
REQ-012 SHALL have dsm_out  output  1  registered 1-bit modulator output.
REQ-013 SHALL have underrun  output  1  sticky flag: a sample load found the holding buffer empty.
REQ-014 SHALL have sat_flag  output  1  sticky flag: an accumulator clipped.

Function
REQ-015 SHALL use a divider counter that runs 0..DIV-1 while in RUN; the tick is asserted in the cycle where the count equals DIV-1.
REQ-016 SHALL implement a FSM with two states, IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE on the first tick with enable=0.
REQ-017 SHALL hold the divider, the OSR counter, the accumulators and dsm_out at zero while in IDLE.
REQ-018 SHALL implement a one-entry holding buffer: s_ready = ~buf_full; a transfer occurs when s_valid and s_ready are both 1.
REQ-019 SHALL count ticks 0..OSR-1 with the OSR counter; on the tick where the count is 0 (the load tick), it SHALL copy the buffer to the active sample and clear buf_full.
REQ-020 SHALL keep the previous active sample and set underrun when the buffer is empty on a load tick.
REQ-021 SHALL set buf_full when a transfer and a load coincide in the same cycle; the new sample stays in the buffer and is not consumed.
REQ-022 SHALL apply feedback f = +2^(WIDTH-1) when dsm_out=1 and -2^(WIDTH-1) when dsm_out=0.
REQ-023 SHALL sign-extend the active sample x to WIDTH+EXT bits before any arithmetic.
REQ-024 SHALL, on each tick, compute a1' = sat(a1 + x - f) and, when ORDER=2, a2' = sat(a2 + a1' - f), using the updated a1'.
REQ-025 SHALL clamp sat() to the range [-(2^(WIDTH+EXT-1)), 2^(WIDTH+EXT-1)-1] and set sat_flag whenever it clips.
REQ-026 SHALL, on each tick, set dsm_out to the inverted MSB of the last-stage accumulator's new value (latency: one edge), and hold dsm_out between ticks.
REQ-027 SHALL keep the ones density of dsm_out equal to (1 + x/2^(WIDTH-1))/2 in steady state.
REQ-028 SHALL clear underrun and sat_flag only on reset or on an IDLE->RUN transition.
REQ-029 SHALL keep the holding buffer contents across RUN->IDLE, so a sample loaded before enable is used at the first load tick.

Reset
REQ-030 SHALL, on rst=0, immediately (without a clock edge) force state=IDLE, all counters=0, accumulators=0, buf_full=0, dsm_out=0, underrun=0 and sat_flag=0; s_ready is then 1.
REQ-031 SHALL abandon any operation in progress when rst is asserted, and SHALL resume in IDLE on the first edge after release.

Structure
REQ-032 SHALL place the state enum (IDLE, RUN) and the legal-ORDER constants in the shared package dsm_pkg.
REQ-033 SHALL implement one accumulator stage (saturating add, clip flag) as the sub-module dsm_integrator, instantiated ORDER times.

Verification
All scenarios use WIDTH=16, EXT=4, ORDER=2, DIV=4, OSR=8.
REQ-034 SHALL cover a steady-input test: enable=1, s_data=0x0000 supplied every load -> dsm_out ones density 50% +/-1 count over 1024 ticks, with underrun=0 and sat_flag=0.
REQ-035 SHALL cover a scaled-input test: s_data=0x4000 -> ones density 75% +/-1 count over 1024 ticks; s_data=0xC000 -> 25%.
REQ-036 SHALL cover an underrun test: one sample is loaded, then s_valid=0 -> underrun rises on the next load tick, 32 clk cycles after the first load.
REQ-037 SHALL cover a backpressure test: s_valid held at 1 with the buffer full -> s_ready=0 until the load-tick cycle; s_ready=1 the cycle after the load; exactly one sample is accepted per 32 clks.
REQ-038 SHALL cover a mid-run reset test: rst is pulsed low between clock edges during RUN -> dsm_out, s_ready and the flags take their reset values before the next edge; after release the block stays in IDLE until enable is sampled high.
REQ-039 SHALL cover a disable test: enable falls mid-sample -> dsm_out holds until the next tick, then is 0 in IDLE; on re-enable the flags are cleared.
